// File: rtl/vga_sprite_engine_if.sv
// vga_sprite_engine_if: sprite ROM bus and VGA DAC pins of the sprite engine.
//   rom_addr    texel address, row-major (ty*SPR_W+tx), driven by the engine
//   rom_data    texel returned by a synchronous ROM one clk after rom_addr
//   VGA_R/G/B   pixel colour, VGA_BITS per channel
//   VGA_HS/VS   active-low syncs
//   VGA_BLANK_N high inside the visible area
//   frame_start one-clk pulse on output pixel (0,0)
// master = engine side, slave = ROM/DAC side.
interface vga_sprite_engine_if #(
  parameter int unsigned VGA_BITS  = 4,
  parameter int unsigned ADDR_BITS = 9
) ();
  logic [ADDR_BITS-1:0] rom_addr;
  logic [7:0]           rom_data;
  logic [VGA_BITS-1:0]  VGA_R;
  logic [VGA_BITS-1:0]  VGA_G;
  logic [VGA_BITS-1:0]  VGA_B;
  logic                 VGA_HS;
  logic                 VGA_VS;
  logic                 VGA_BLANK_N;
  logic                 frame_start;

  modport master (
    output rom_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start,
    input  rom_data
  );

  modport slave (
    input  rom_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start,
    output rom_data
  );
endinterface

// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: VGA timing generator that overlays a scaled sprite fetched
// from an external synchronous ROM, with per-frame colour/gray/invert/noise modes.
//   clk       pixel clock
//   reset     synchronous, active-high
//   mode      0 colour, 1 gray, 2 inverted, 3 noise background (latched per frame)
//   sprite_x  sprite left edge in pixels (latched per frame)
//   sprite_y  sprite top edge in lines (latched per frame)
//   bus       ROM address/data and VGA output pins (master side)
// All outputs lag the internal h/v position by three clocks.
module vga_sprite_engine #(
  parameter int unsigned VGA_BITS   = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SPR_W      = 16,
  parameter int unsigned SPR_H      = 32,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned ADDR_BITS  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [9:0] sprite_x,
  input  logic [9:0] sprite_y,
  vga_sprite_engine_if.master bus
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  // Offsets carry one extra bit so a negative difference shows up as a borrow.
  localparam int unsigned DW       = 11;
  localparam int unsigned SW_PIX   = SPR_W << SCALE_LOG2;
  localparam int unsigned SH_PIX   = SPR_H << SCALE_LOG2;
  localparam int unsigned TXW      = $clog2(SPR_W);
  localparam int unsigned TYW      = $clog2(SPR_H);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [HW-1:0]        h;
  logic [VW-1:0]        v;
  logic                 frame_origin_c;
  logic [9:0]           sx_q, sy_q, sx_c, sy_c;
  logic [1:0]           mode_q;
  logic [DW-1:0]        dx, dy;
  logic [TXW-1:0]       tx;
  logic [TYW-1:0]       ty;
  logic                 active_c, hit_c, hs_raw_c, vs_raw_c;
  logic [ADDR_BITS-1:0] addr_c;
  logic [15:0]          lfsr;
  logic                 hit1, hs1, vs1, act1, fs1;
  logic                 hit2, hs2, vs2, act2, fs2;
  logic [7:0]           r8, g8, b8, r_c, g_c, b_c;
  logic [9:0]           y10;
  logic                 spr_vis;
  logic                 unused_bits;

  // Raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  assign frame_origin_c = (h == '0) && (v == '0);

  // Per-frame shadow of the control inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sx_q   <= '0;
      sy_q   <= '0;
      mode_q <= '0;
    end else if (frame_origin_c) begin
      sx_q   <= sprite_x;
      sy_q   <= sprite_y;
      mode_q <= mode;
    end
  end

  // Pixel (0,0) is tested against the values being latched on this very clock.
  assign sx_c = frame_origin_c ? sprite_x : sx_q;
  assign sy_c = frame_origin_c ? sprite_y : sy_q;

  // Hit test and texel address; the borrow bit marks pixels left of / above the sprite.
  assign active_c = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
  assign dx       = DW'(h) - DW'(sx_c);
  assign dy       = DW'(v) - DW'(sy_c);
  assign hit_c    = active_c
                 && !dx[DW-1] && (dx < DW'(SW_PIX))
                 && !dy[DW-1] && (dy < DW'(SH_PIX));
  assign tx       = dx[SCALE_LOG2 +: TXW];
  assign ty       = dy[SCALE_LOG2 +: TYW];
  assign addr_c   = ADDR_BITS'({ty, tx});
  assign hs_raw_c = !((32'(h) >= HS_START) && (32'(h) < HS_END));
  assign vs_raw_c = !((32'(v) >= VS_START) && (32'(v) < VS_END));

  // Free-running noise source, taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Stage 1: ROM address, hit and raw syncs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rom_addr <= '0;
      hit1 <= 1'b0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      act1 <= 1'b0;
      fs1  <= 1'b0;
    end else begin
      if (hit_c) bus.rom_addr <= addr_c;
      hit1 <= hit_c;
      hs1  <= hs_raw_c;
      vs1  <= vs_raw_c;
      act1 <= active_c;
      fs1  <= frame_origin_c;
    end
  end

  // Stage 2: ROM data arrives; delay the controls to match.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit2 <= 1'b0;
      hs2  <= 1'b1;
      vs2  <= 1'b1;
      act2 <= 1'b0;
      fs2  <= 1'b0;
    end else begin
      hit2 <= hit1;
      hs2  <= hs1;
      vs2  <= vs1;
      act2 <= act1;
      fs2  <= fs1;
    end
  end

  // Stage 3 colour: expand texel, apply mode, pick background, blank.
  always_comb begin
    r8      = {4{bus.rom_data[5:4]}};
    g8      = {4{bus.rom_data[3:2]}};
    b8      = {4{bus.rom_data[1:0]}};
    y10     = 10'(r8) + 10'({g8, 1'b0}) + 10'(b8);
    spr_vis = hit2 && !bus.rom_data[7];
    r_c     = '0;
    g_c     = '0;
    b_c     = '0;
    if (spr_vis) begin
      case (mode_q)
        2'd1: begin
          r_c = y10[9:2];
          g_c = y10[9:2];
          b_c = y10[9:2];
        end
        2'd2: begin
          r_c = ~r8;
          g_c = ~g8;
          b_c = ~b8;
        end
        default: begin
          r_c = r8;
          g_c = g8;
          b_c = b8;
        end
      endcase
    end else if (mode_q == 2'd3) begin
      r_c = lfsr[15:8];
      g_c = lfsr[7:0];
      b_c = lfsr[15:8] ^ lfsr[7:0];
    end
    if (!act2) begin
      r_c = '0;
      g_c = '0;
      b_c = '0;
    end
  end

  assign unused_bits = ^{bus.rom_data[6], y10[1:0]};

  // Stage 3: registered pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.VGA_R       <= '0;
      bus.VGA_G       <= '0;
      bus.VGA_B       <= '0;
      bus.VGA_HS      <= 1'b1;
      bus.VGA_VS      <= 1'b1;
      bus.VGA_BLANK_N <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.VGA_R       <= r_c[7 -: VGA_BITS];
      bus.VGA_G       <= g_c[7 -: VGA_BITS];
      bus.VGA_B       <= b_c[7 -: VGA_BITS];
      bus.VGA_HS      <= hs2;
      bus.VGA_VS      <= vs2;
      bus.VGA_BLANK_N <= act2;
      bus.frame_start <= fs2;
    end
  end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb_vga_sprite_engine: randomized bench for vga_sprite_engine on a shrunken
// raster (80x55 total, 64x48 visible) with an 8x8 sprite magnified 4x.
// A pixel-level reference model derives every output from the frame parameters
// captured at each frame origin, the ROM image and an independent LFSR model.
module tb_vga_sprite_engine;

  localparam int VB       = 4;
  localparam int HA       = 64;
  localparam int HFP      = 4;
  localparam int HSY      = 8;
  localparam int HBP      = 4;
  localparam int VA       = 48;
  localparam int VFP      = 2;
  localparam int VSY      = 2;
  localparam int VBP      = 3;
  localparam int SW       = 8;
  localparam int SH       = 8;
  localparam int SL       = 2;
  localparam int AB       = 6;
  localparam int HT       = HA + HFP + HSY + HBP;
  localparam int VT       = VA + VFP + VSY + VBP;
  localparam int FRAME    = HT * VT;
  localparam int SCALE    = 1 << SL;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic [7:0] rom [SW*SH];

  vga_sprite_engine_if #(.VGA_BITS(VB), .ADDR_BITS(AB)) bus ();

  vga_sprite_engine #(
    .VGA_BITS(VB), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SPR_W(SW), .SPR_H(SH), .SCALE_LOG2(SL), .ADDR_BITS(AB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .sprite_x (sprite_x),
    .sprite_y (sprite_y),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROM.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int          checks;
  int          failures;
  int          t;
  int          mcount;
  int          fr_sx[$];
  int          fr_sy[$];
  int          fr_mode[$];
  logic [15:0] lf_cur;
  logic [15:0] lf_prev;
  int          exp_addr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  task automatic snapshot();
    fr_sx.push_back(int'(sprite_x));
    fr_sy.push_back(int'(sprite_y));
    fr_mode.push_back(int'(mode));
  endtask

  // Sprite coverage and texel index for the pixel at raster index p.
  task automatic sprite_lookup(input int p, output bit hit, output int addr);
    int h, v, f, sx, sy;
    h    = p % HT;
    v    = (p / HT) % VT;
    f    = p / FRAME;
    sx   = fr_sx[f];
    sy   = fr_sy[f];
    hit  = (h < HA) && (v < VA) && (h >= sx) && (h < sx + SW * SCALE)
        && (v >= sy) && (v < sy + SH * SCALE);
    addr = hit ? ((v - sy) / SCALE) * SW + (h - sx) / SCALE : 0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_r"},     32'(bus.VGA_R), 0);
    check_val({tag, "_g"},     32'(bus.VGA_G), 0);
    check_val({tag, "_b"},     32'(bus.VGA_B), 0);
    check_val({tag, "_hs"},    32'(bus.VGA_HS), 1);
    check_val({tag, "_vs"},    32'(bus.VGA_VS), 1);
    check_val({tag, "_blank"}, 32'(bus.VGA_BLANK_N), 0);
    check_val({tag, "_fs"},    32'(bus.frame_start), 0);
    check_val({tag, "_addr"},  32'(bus.rom_addr), 0);
  endtask

  // Compare the pins at interval t against the pixel from raster index t-3.
  task automatic check_outputs();
    int p, h, v, f, addr, m, r8, g8, b8, y;
    bit hit, active, opaque;
    int er, eg, eb, ehs, evs, ebl, efs;
    logic [7:0] tex;
    p = t - 3;
    if (p < 0) begin
      er = 0; eg = 0; eb = 0; ehs = 1; evs = 1; ebl = 0; efs = 0;
    end else begin
      h      = p % HT;
      v      = (p / HT) % VT;
      f      = p / FRAME;
      m      = fr_mode[f];
      active = (h < HA) && (v < VA);
      sprite_lookup(p, hit, addr);
      tex    = rom[addr];
      opaque = hit && !tex[7];
      r8     = int'(tex[5:4]) * 85;
      g8     = int'(tex[3:2]) * 85;
      b8     = int'(tex[1:0]) * 85;
      if (opaque) begin
        if (m == 1) begin
          y  = (r8 + 2 * g8 + b8) / 4;
          r8 = y; g8 = y; b8 = y;
        end else if (m == 2) begin
          r8 = 255 - r8; g8 = 255 - g8; b8 = 255 - b8;
        end
      end else if (m == 3) begin
        r8 = int'(lf_prev[15:8]);
        g8 = int'(lf_prev[7:0]);
        b8 = r8 ^ g8;
      end else begin
        r8 = 0; g8 = 0; b8 = 0;
      end
      er  = active ? r8 >> (8 - VB) : 0;
      eg  = active ? g8 >> (8 - VB) : 0;
      eb  = active ? b8 >> (8 - VB) : 0;
      ehs = (h >= HA + HFP && h < HA + HFP + HSY) ? 0 : 1;
      evs = (v >= VA + VFP && v < VA + VFP + VSY) ? 0 : 1;
      ebl = active ? 1 : 0;
      efs = (h == 0 && v == 0) ? 1 : 0;
    end
    check_val("vga_r",   32'(bus.VGA_R), er);
    check_val("vga_g",   32'(bus.VGA_G), eg);
    check_val("vga_b",   32'(bus.VGA_B), eb);
    check_val("vga_hs",  32'(bus.VGA_HS), ehs);
    check_val("vga_vs",  32'(bus.VGA_VS), evs);
    check_val("blank_n", 32'(bus.VGA_BLANK_N), ebl);
    check_val("frame_start", 32'(bus.frame_start), efs);
    check_val("rom_addr", 32'(bus.rom_addr), exp_addr);
  endtask

  task automatic start_after_reset();
    reset = 1'b0;
    t     = 0;
    fr_sx.delete();
    fr_sy.delete();
    fr_mode.delete();
    lf_cur   = 16'hACE1;
    lf_prev  = 16'hACE1;
    exp_addr = 0;
    snapshot();
    check_outputs();
  endtask

  task automatic run(input int n);
    bit hit;
    int addr;
    repeat (n) begin
      @(posedge clk);
      #1;
      t++;
      lf_prev = lf_cur;
      lf_cur  = lfsr_next(lf_cur);
      sprite_lookup(t - 1, hit, addr);
      if (hit) exp_addr = addr;
      check_outputs();
      // Mid-frame control change: must only take effect from the next frame.
      if (t % FRAME == FRAME / 2) begin
        mcount++;
        mode     = 2'(mcount % 4);
        sprite_x = (mcount % 3 == 2) ? 10'd58 : 10'($urandom_range(0, 60));
        sprite_y = 10'($urandom_range(0, 40));
      end
      if (t % FRAME == 0) snapshot();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    t        = 0;
    mcount   = 0;
    reset    = 1'b1;
    mode     = 2'd0;
    sprite_x = 10'd10;
    sprite_y = 10'd5;
    for (int i = 0; i < SW * SH; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0] = 8'h30;
    rom[1] = 8'h1B;
    rom[2] = 8'h80;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");

    start_after_reset();
    // Stop with the raster at h=30, v=20 of frame 6, then reset mid-line.
    run(6 * FRAME + 20 * HT + 30);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_state("midrst");
    end

    start_after_reset();
    run(3 * FRAME + 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
